mem_arbiter: RTL

- Sequences a single-ported RAM between the instruction cache and the data cache.
- Sits between both caches and the RAM model. Presents the per-requester wait/load interface that the pipeline's hazard logic stalls on.
- Dcache has priority by default. A starvation counter forces an icache grant after a bounded number of consecutive dcache wins.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side signals of the memory arbiter.
//
// Handshake: a requester raises its request (iREN, or dREN/dWEN) and keeps it
// asserted, together with a stable address and store data, until its wait
// output is low on a clock edge. Read data (iload/dload) is valid only in that
// cycle. Dropping the request before then abandons the access. The RAM side
// is ramstate driven: FREE/BUSY hold the access, ACCESS completes it and
// ERROR fails it.
//
// Modports:
//   slave  - arbiter view: request inputs from both caches, RAM commands out
//   master - environment view: caches and RAM model
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported RAM between the icache and dcache.
// The dcache wins contended arbitration unless the icache has lost
// STARVE_LIMIT consecutive contended rounds, in which case the icache wins.
//
// Ports:
//   CLK            system clock, rising edge
//   nRST           asynchronous active-low reset
//   bus            mem_arbiter_if.slave (cache requests, RAM commands)
//   dbg_state      current FSM state (0=IDLE, 1=GNT_I, 2=GNT_D)
//   dbg_starve_cnt current starvation counter value
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;
  localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);

  state_t        state, state_next;
  logic [CW-1:0] starve_cnt, starve_next;

  logic        dreq;
  logic        iwait, dwait, ram_ren, ram_wen, err;
  logic [31:0] ram_addr, ram_store, iload, dload;

  assign dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // All outputs are combinational from state, so the asynchronous reset
  // forcing IDLE also forces every output to its idle/reset value.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    iwait       = 1'b1;
    dwait       = 1'b1;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;
    iload       = '0;
    dload       = '0;
    err         = 1'b0;

    unique case (state)
      IDLE: begin
        if (dreq && bus.iREN) begin
          if (starve_cnt == LIMIT) begin
            state_next  = GNT_I;
            starve_next = '0;
          end else begin
            state_next  = GNT_D;
            starve_next = starve_cnt + CW'(1);
          end
        end else if (dreq) begin
          state_next = GNT_D;
        end else if (bus.iREN) begin
          state_next  = GNT_I;
          starve_next = '0;
        end else begin
          starve_next = '0;
        end
      end

      GNT_D: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        dload     = bus.ramload;
        if (!dreq) begin
          // Abort: enables already low via defaults, no completion.
          state_next = IDLE;
        end else begin
          // Write has precedence when both dREN and dWEN are high.
          ram_wen = bus.dWEN;
          ram_ren = bus.dREN & ~bus.dWEN;
          if (bus.ramstate == RAM_ACCESS) begin
            dwait      = 1'b0;
            state_next = IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            err        = 1'b1;
            state_next = IDLE;
          end
        end
      end

      GNT_I: begin
        ram_addr = bus.iaddr;
        iload    = bus.ramload;
        if (!bus.iREN) begin
          state_next = IDLE;
        end else begin
          ram_ren = 1'b1;
          if (bus.ramstate == RAM_ACCESS) begin
            iwait      = 1'b0;
            state_next = IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            err        = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.err      = err;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule
